countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter that counts a value down to zero at a prescaled rate and emits a one-cycle `expired` pulse. It is the count-down counterpart of the free-running up-counter. It serves as the game's turn and deal-delay timer: control logic loads a duration and waits for expiry. It supports pause/resume and abort, and optionally runs periodically.

## Interface
- `WIDTH`, 16, width of `load_value` and `remaining`.
- `PRESCALE`, 1000, number of `clk` cycles per decrement of `remaining`. Must be ≥1; the internal prescale counter is $clog2(PRESCALE) bits, minimum 1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to load `load_value` and begin counting.
- `load_value`  in  WIDTH  duration in prescaled ticks; sampled only when `start` is high.
- `pause`  in  1  level; while high, counting is frozen.
- `abort`  in  1  one-cycle request to stop immediately without expiry.
- `busy`  out  1  high in RUN or HOLD.
- `paused`  out  1  high in HOLD.
- `expired`  out  1  registered, high for exactly one cycle when `remaining` reaches 0.
- `remaining`  out  WIDTH  current count, registered.

## Operation
- States:
  - IDLE: stopped.
  - RUN: counting.
  - HOLD: paused.
- Internal registers: state, `remaining`, prescale counter `pcnt`, `reload_val`, `expired`.
- Per-edge priority: `reset` low > `abort` > `start` > terminal count > `pause` > normal count.
- `reset` low:
  - State IDLE; `remaining`, `pcnt`, `reload_val` = 0.
  - `expired`, `busy`, `paused` = 0.
- `abort`, any state:
  - Go to IDLE; `remaining` = 0, `pcnt` = 0.
  - No `expired` pulse; an `abort` coinciding with the terminal decrement suppresses the pulse.
- `start`, any state including RUN and HOLD (restart):
  - `remaining` = `load_value`, `reload_val` = `load_value`, `pcnt` = 0.
  - Next state is HOLD if `pause` is high, else RUN.
  - If `load_value` = 0: stay in or go to IDLE and pulse `expired` next cycle.
- RUN with `pause` low:
  - `pcnt` increments each cycle.
  - When `pcnt` = PRESCALE-1: `pcnt` = 0 and `remaining` decrements by 1.
  - If `remaining` was 1, this is the terminal count: `remaining` = 0, `expired` = 1 next cycle, then the end-of-count action below.
- RUN with `pause` high: go to HOLD; `pcnt` and `remaining` hold; no decrement that cycle.
- HOLD with `pause` low: go to RUN. `pcnt` resumes from its held value; no cycles are lost or gained.
- `expired` is 0 on every cycle except the one following a terminal count or zero-length start.
- `remaining` never wraps below 0. Decrement occurs only in RUN with `remaining` ≥ 1.
- Outputs `busy` and `paused` decode from the state register (no combinational input path).

## Timing
- Start-to-expiry latency: `start` sampled at edge 0 with `load_value` = N ≥ 1 and no pause. Then `expired` is high during the cycle after edge N·PRESCALE, and `busy` falls at that same edge.
- `remaining` first changes (to N-1) at edge PRESCALE.
- A pause of K cycles extends the latency by exactly K cycles.
- Restart in the middle of a count discards all progress; latency is measured from the new `start`.
- `start` and `abort` in the same cycle: `abort` wins; the timer is IDLE with `remaining` = 0.
- `start` in the same cycle as a terminal count: `start` wins, no `expired` pulse, and the count reloads.
- Zero-length start: `expired` high one cycle after the `start` edge; `busy` stays 0.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined (periodic mode):
  - On terminal count: `remaining` = `reload_val`, `pcnt` = 0, state stays RUN, `expired` pulses once every `reload_val`·PRESCALE cycles.
  - Only `abort` or `reset` stops the timer.
  - A zero-length start still expires once and goes IDLE.
- Undefined (one-shot mode): terminal count goes to IDLE with `remaining` = 0.

## Test plan
- Reset, basic count: PRESCALE=4. Assert `reset`=0 for 2 cycles, then `start` with `load_value`=3 → `remaining` goes 3, 2, 1, 0 at edges 0, 4, 8, 12. `expired` high for exactly 1 cycle after edge 12; `busy` then 0.
- Pause: PRESCALE=4, load 3, `pause` high for 5 cycles starting at cycle 6 → `paused`=1 for those 5 cycles, `remaining` frozen at 2, expiry at edge 17.
- Abort and collisions:
  - Abort at cycle 5 → IDLE, `remaining`=0, no `expired` for 20 cycles.
  - `start` and `abort` in the same cycle → IDLE.
- Restart and terminal collision: load 3, re-`start` with 5 at cycle 6 → expiry at 6+20 with no earlier pulse. Also `start` coinciding with the terminal edge → no pulse, `remaining` = new value.
- Zero length: `start` with `load_value`=0 → `expired` high next cycle, `busy` never high.
- Periodic (`COUNTDOWN_AUTORELOAD_EN` defined), PRESCALE=2, load 2 → `expired` at edges 4, 8, 12, ..., `busy` stays 1; `abort` at edge 9 → no further pulses.

Source files
------------

// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_if
//  Description : Control/status bundle between game control logic and the
//                countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] load_value;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             paused;
  logic             expired;
  logic [WIDTH-1:0] remaining;

  modport master (
    output start, load_value, pause, abort,
    input  busy, paused, expired, remaining
  );

  modport slave (
    input  start, load_value, pause, abort,
    output busy, paused, expired, remaining
  );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable prescaled down-counter with pause, abort and a
//                one-cycle expiry pulse. Define COUNTDOWN_AUTORELOAD_EN for
//                periodic (auto-reload) operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  countdown_timer_if.slave       bus
);

  localparam int                c_PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_remaining;
  logic [WIDTH-1:0]    w_remaining_nxt;
  logic [WIDTH-1:0]    r_reload_val;
  logic [WIDTH-1:0]    w_reload_val_nxt;
  logic [c_PCNT_W-1:0] r_pcnt;
  logic [c_PCNT_W-1:0] w_pcnt_nxt;
  logic                r_expired;
  logic                w_expired_nxt;

  logic                w_active;
  logic                w_terminal;

  // HOLD releasing into RUN counts on the same edge so a K-cycle pause costs exactly K cycles.
  assign w_active   = (r_state == S_RUN) || ((r_state == S_HOLD) && !bus.pause);
  assign w_terminal = w_active && (r_pcnt == c_PCNT_MAX) && (r_remaining == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_reload_val <= '0;
      r_pcnt       <= '0;
      r_expired    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_reload_val <= w_reload_val_nxt;
      r_pcnt       <= w_pcnt_nxt;
      r_expired    <= w_expired_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_remaining_nxt  = r_remaining;
    w_reload_val_nxt = r_reload_val;
    w_pcnt_nxt       = r_pcnt;
    w_expired_nxt    = 1'b0;

    if (bus.abort) begin
      w_state_nxt     = S_IDLE;
      w_remaining_nxt = '0;
      w_pcnt_nxt      = '0;
    end else if (bus.start) begin
      w_remaining_nxt  = bus.load_value;
      w_reload_val_nxt = bus.load_value;
      w_pcnt_nxt       = '0;
      if (bus.load_value == '0) begin
        w_state_nxt   = S_IDLE;
        w_expired_nxt = 1'b1;
      end else begin
        w_state_nxt = bus.pause ? S_HOLD : S_RUN;
      end
    end else if (w_terminal) begin
      w_expired_nxt = 1'b1;
      w_pcnt_nxt    = '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      w_remaining_nxt = r_reload_val;
      w_state_nxt     = S_RUN;
`else
      w_remaining_nxt = '0;
      w_state_nxt     = S_IDLE;
`endif
    end else if ((r_state != S_IDLE) && bus.pause) begin
      w_state_nxt = S_HOLD;
    end else if (w_active) begin
      w_state_nxt = S_RUN;
      if (r_pcnt == c_PCNT_MAX) begin
        w_pcnt_nxt = '0;
        if (r_remaining != '0) begin
          w_remaining_nxt = r_remaining - WIDTH'(1);
        end
      end else begin
        w_pcnt_nxt = r_pcnt + c_PCNT_W'(1);
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.paused    = (r_state == S_HOLD);
  assign bus.expired   = r_expired;
  assign bus.remaining = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Directed self-checking bench for countdown_timer, PRESCALE=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit c_AUTO = 1'b1;
`else
  localparam bit c_AUTO = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  countdown_timer_if #(.WIDTH(16)) bus ();

  countdown_timer #(.WIDTH(16), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b1;
    bus.load_value = 16'd5;
    tick();
    tick();
    n_checks++; if (bus.remaining !== 16'd0) begin n_fails++; $display("FAIL reset_remaining: got %0d expected 0", bus.remaining); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.paused !== 1'b0) begin n_fails++; $display("FAIL reset_paused: got %b expected 0", bus.paused); end
    n_checks++; if (bus.expired !== 1'b0) begin n_fails++; $display("FAIL reset_expired: got %b expected 0", bus.expired); end
    bus.start = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] exp_rem;
    bus.start = 1'b1;
    bus.load_value = 16'd3;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.remaining !== 16'd3) begin n_fails++; $display("FAIL basic_load: got %0d expected 3", bus.remaining); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fails++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_rem = (e == 12 && c_AUTO) ? 16'd3 : 16'(3 - e / 4);
      n_checks++; if (bus.remaining !== exp_rem) begin n_fails++; $display("FAIL basic_rem@%0d: got %0d expected %0d", e, bus.remaining, exp_rem); end
      n_checks++; if (bus.expired !== (e == 12)) begin n_fails++; $display("FAIL basic_exp@%0d: got %b expected %b", e, bus.expired, (e == 12)); end
    end
    n_checks++; if (bus.busy !== c_AUTO) begin n_fails++; $display("FAIL basic_busy_end: got %b expected %b", bus.busy, c_AUTO); end
    tick();
    n_checks++; if (bus.expired !== 1'b0) begin n_fails++; $display("FAIL basic_pulse_width: got %b expected 0", bus.expired); end
    go_idle();
  endtask

  task automatic test_pause();
    int          counted;
    logic [15:0] exp_rem;
    logic        held;
    bus.start = 1'b1;
    bus.load_value = 16'd3;
    tick();
    bus.start = 1'b0;
    counted = 0;
    for (int e = 1; e <= 17; e++) begin
      held = (e >= 6) && (e <= 10);
      bus.pause = held;
      tick();
      if (!held) counted++;
      exp_rem = (e == 17 && c_AUTO) ? 16'd3 : 16'(3 - counted / 4);
      n_checks++; if (bus.paused !== held) begin n_fails++; $display("FAIL pause_paused@%0d: got %b expected %b", e, bus.paused, held); end
      n_checks++; if (bus.remaining !== exp_rem) begin n_fails++; $display("FAIL pause_rem@%0d: got %0d expected %0d", e, bus.remaining, exp_rem); end
      n_checks++; if (bus.expired !== (e == 17)) begin n_fails++; $display("FAIL pause_exp@%0d: got %b expected %b", e, bus.expired, (e == 17)); end
    end
    bus.pause = 1'b0;
    go_idle();
  endtask

  task automatic test_abort();
    int pulses;
    bus.start = 1'b1;
    bus.load_value = 16'd3;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.remaining !== 16'd0) begin n_fails++; $display("FAIL abort_rem: got %0d expected 0", bus.remaining); end
    pulses = 0;
    repeat (20) begin
      tick();
      if (bus.expired) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fails++; $display("FAIL abort_no_pulse: got %0d pulses expected 0", pulses); end

    // Abort landing on the terminal edge must swallow the pulse.
    bus.start = 1'b1;
    bus.load_value = 16'd1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++; if (bus.expired !== 1'b0) begin n_fails++; $display("FAIL abort_terminal_exp: got %b expected 0", bus.expired); end
    tick();
    n_checks++; if (bus.expired !== 1'b0) begin n_fails++; $display("FAIL abort_terminal_exp2: got %b expected 0", bus.expired); end

    bus.start = 1'b1;
    bus.load_value = 16'd3;
    tick();
    repeat (2) begin bus.start = 1'b0; tick(); end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.load_value = 16'd7;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL start_abort_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.remaining !== 16'd0) begin n_fails++; $display("FAIL start_abort_rem: got %0d expected 0", bus.remaining); end
  endtask

  task automatic test_restart();
    int pulses;
    bus.start = 1'b1;
    bus.load_value = 16'd3;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 26; e++) begin
      if (e == 6) begin
        bus.start = 1'b1;
        bus.load_value = 16'd5;
      end
      tick();
      bus.start = 1'b0;
      if (e == 6) begin
        n_checks++; if (bus.remaining !== 16'd5) begin n_fails++; $display("FAIL restart_rem: got %0d expected 5", bus.remaining); end
      end
      if (e < 26 && bus.expired) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fails++; $display("FAIL restart_early_pulse: got %0d pulses expected 0", pulses); end
    n_checks++; if (bus.expired !== 1'b1) begin n_fails++; $display("FAIL restart_expiry: got %b expected 1", bus.expired); end
    go_idle();

    // Start on the terminal edge wins over the expiry.
    bus.start = 1'b1;
    bus.load_value = 16'd1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.start = 1'b1;
    bus.load_value = 16'd2;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.expired !== 1'b0) begin n_fails++; $display("FAIL collide_exp: got %b expected 0", bus.expired); end
    n_checks++; if (bus.remaining !== 16'd2) begin n_fails++; $display("FAIL collide_rem: got %0d expected 2", bus.remaining); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fails++; $display("FAIL collide_busy: got %b expected 1", bus.busy); end
    pulses = 0;
    for (int e = 5; e <= 11; e++) begin
      tick();
      if (bus.expired) pulses++;
    end
    tick();
    n_checks++; if (pulses !== 0) begin n_fails++; $display("FAIL collide_early_pulse: got %0d pulses expected 0", pulses); end
    n_checks++; if (bus.expired !== 1'b1) begin n_fails++; $display("FAIL collide_expiry: got %b expected 1", bus.expired); end
    go_idle();
  endtask

  task automatic test_zero_length();
    bus.start = 1'b1;
    bus.load_value = 16'd0;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.expired !== 1'b1) begin n_fails++; $display("FAIL zero_exp: got %b expected 1", bus.expired); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL zero_busy: got %b expected 0", bus.busy); end
    tick();
    n_checks++; if (bus.expired !== 1'b0) begin n_fails++; $display("FAIL zero_exp_width: got %b expected 0", bus.expired); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL zero_busy2: got %b expected 0", bus.busy); end

    bus.start = 1'b1;
    bus.load_value = 16'd4;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    bus.start = 1'b1;
    bus.load_value = 16'd0;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.expired !== 1'b1) begin n_fails++; $display("FAIL zero_restart_exp: got %b expected 1", bus.expired); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL zero_restart_busy: got %b expected 0", bus.busy); end
    tick();
  endtask

`ifdef COUNTDOWN_AUTORELOAD_EN
  task automatic test_periodic();
    bus.start = 1'b1;
    bus.load_value = 16'd2;
    tick();
    bus.start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      bus.abort = (e == 18);
      tick();
      n_checks++; if (bus.expired !== (e == 8 || e == 16)) begin n_fails++; $display("FAIL periodic_exp@%0d: got %b expected %b", e, bus.expired, (e == 8 || e == 16)); end
      n_checks++; if (bus.busy !== (e < 18)) begin n_fails++; $display("FAIL periodic_busy@%0d: got %b expected %b", e, bus.busy, (e < 18)); end
    end
    bus.abort = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.load_value = '0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_basic();
    test_pause();
    test_abort();
    test_restart();
    test_zero_length();
`ifdef COUNTDOWN_AUTORELOAD_EN
    test_periodic();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
